// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller for a multi-level VGA game.
// The flow is PRE -> PLAY -> WIN/LOSE -> PRE, with DONE after the last level.
// A one-second prescaler drives the level countdown and the WIN/LOSE dwell time.
// Optional feature: define LEVEL_SEQ_LIVES_EN to enable lives counting and the OVER state.
// Without that macro, lives stays at START_LIVES and LOSE always returns to PRE.
module level_sequencer #(
   parameter int CLOCK_HZ      = 25000000,
   parameter int NUM_LEVELS    = 3,
   parameter int LEVEL_SECONDS = 60,
   parameter int HOLD_SECONDS  = 2,
   parameter int START_LIVES   = 3
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       jump_button,
   input  logic       level_win,
   input  logic       level_lose,
   output logic [1:0] level_select,
   output logic       level_reset,
   output logic [6:0] seconds,
   output logic [1:0] lives,
   output logic [2:0] game_state,
   output logic [9:0] leds
);

   localparam int PW = (CLOCK_HZ > 1)     ? $clog2(CLOCK_HZ)     : 1;
   localparam int HW = (HOLD_SECONDS > 1) ? $clog2(HOLD_SECONDS) : 1;

   typedef enum logic [2:0] {
      S_PRE  = 3'd0,
      S_PLAY = 3'd1,
      S_WIN  = 3'd2,
      S_LOSE = 3'd3,
      S_OVER = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            btn_q;
   logic [PW-1:0]   pre_q, pre_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [1:0]      level_q, level_d;
   logic [1:0]      sel_q, sel_d;
   logic            lrst_q, lrst_d;
   logic            guard_q, guard_d;
   logic [6:0]      sec_q, sec_d;

   logic            start;
   logic            tick;
   logic            hold_done;
   logic            flags_ok;
   logic            entry;
   logic            lives_zero;

   // A press counts only on the cycle the button goes from low to high.
   assign start     = jump_button & ~btn_q;
   assign tick      = (pre_q == PW'(CLOCK_HZ - 1));
   assign hold_done = tick && (hold_q == HW'(HOLD_SECONDS - 1));
   // The level module is still re-initialising during the reset pulse and the cycle after it.
   assign flags_ok  = (state_q == S_PLAY) && !lrst_q && !guard_q;
   assign entry     = (state_d != state_q);

`ifdef LEVEL_SEQ_LIVES_EN
   logic [1:0] lives_q, lives_d;

   // Lives register: one lost on every LOSE entry, refilled on restart from OVER/DONE.
   always_ff @(posedge vga_clock) begin
      if (reset) lives_q <= 2'(START_LIVES);
      else       lives_q <= lives_d;
   end

   // Next lives value.
   always_comb begin
      lives_d = lives_q;
      if (state_q == S_PLAY && state_d == S_LOSE)
         lives_d = lives_q - 2'd1;
      else if ((state_q == S_OVER || state_q == S_DONE) && state_d == S_PRE)
         lives_d = 2'(START_LIVES);
   end

   assign lives_zero = (lives_q == 2'd0);
   assign lives      = lives_q;
`else
   assign lives_zero = 1'b0;
   assign lives      = 2'(START_LIVES);
`endif

   // State and datapath registers; reset overrides every pending transition.
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state_q <= S_PRE;
         btn_q   <= 1'b1;
         pre_q   <= '0;
         hold_q  <= '0;
         level_q <= 2'd1;
         sel_q   <= 2'd0;
         lrst_q  <= 1'b0;
         guard_q <= 1'b0;
         sec_q   <= 7'(LEVEL_SECONDS);
      end else begin
         state_q <= state_d;
         btn_q   <= jump_button;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         sel_q   <= sel_d;
         lrst_q  <= lrst_d;
         guard_q <= guard_d;
         sec_q   <= sec_d;
      end
   end

   // Next-state logic; a win beats a simultaneous lose or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_PRE:  if (start) state_d = S_PLAY;
         S_PLAY: begin
            if (flags_ok && level_win)
               state_d = S_WIN;
            else if ((flags_ok && level_lose) || sec_q == 7'd0)
               state_d = S_LOSE;
         end
         S_WIN:  if (hold_done)
                    state_d = (level_q == 2'(NUM_LEVELS)) ? S_DONE : S_PRE;
         S_LOSE: if (hold_done)
                    state_d = lives_zero ? S_OVER : S_PRE;
         S_OVER,
         S_DONE: if (start) state_d = S_PRE;
         default: state_d = S_PRE;
      endcase
   end

   // Output and datapath next values; everything leaves the block registered.
   always_comb begin
      pre_d   = (entry || tick) ? '0 : pre_q + PW'(1);
      hold_d  = hold_q;
      if (entry)     hold_d = '0;
      else if (tick) hold_d = hold_q + HW'(1);

      lrst_d  = (state_q == S_PRE) && (state_d == S_PLAY);
      guard_d = lrst_q;

      sec_d = sec_q;
      if (lrst_d)
         sec_d = 7'(LEVEL_SECONDS);
      else if (state_q == S_PLAY && tick && sec_q != 7'd0)
         sec_d = sec_q - 7'd1;

      level_d = level_q;
      if (state_q == S_WIN && state_d == S_PRE)
         level_d = level_q + 2'd1;
      else if ((state_q == S_OVER || state_q == S_DONE) && state_d == S_PRE)
         level_d = 2'd1;

      case (state_d)
         S_PLAY, S_WIN, S_LOSE: sel_d = level_q;
         default:               sel_d = 2'd0;
      endcase
   end

   assign game_state   = state_q;
   assign level_select = sel_q;
   assign level_reset  = lrst_q;
   assign seconds      = sec_q;
   assign leds         = {game_state, lives, level_select, 3'b000};

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 25000000: vga_clock cycles per one-second tick.
REQ-002 SHALL have parameter NUM_LEVELS, default 3: playable levels, indices 1..NUM_LEVELS; index 0 is the pre-level screen.
REQ-003 SHALL have parameter LEVEL_SECONDS, default 60: countdown start value per level.
REQ-004 SHALL have parameter HOLD_SECONDS, default 2: dwell time in WIN/LOSE before advancing.
REQ-005 SHALL have parameter START_LIVES, default 3: lives loaded at reset.
REQ-006 SHALL have port vga_clock, input, 1 bit: sole clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port jump_button, input, 1 bit: start/continue request, level-sensitive raw input.
REQ-009 SHALL have port level_win, input, 1 bit: win flag from the active level module.
REQ-010 SHALL have port level_lose, input, 1 bit: lose flag from the active level module.
REQ-011 SHALL have port level_select, output, 2 bits: index of the level module driving background/sprites.
REQ-012 SHALL have port level_reset, output, 1 bit: one-cycle pulse re-initialising the selected level.
REQ-013 SHALL have port seconds, output, 7 bits: remaining countdown.
REQ-014 SHALL have port lives, output, 2 bits: remaining lives.
REQ-015 SHALL have port game_state, output, 3 bits: PRE=0, PLAY=1, WIN=2, LOSE=3, OVER=4, DONE=5.
REQ-016 SHALL have port leds, output, 10 bits: {game_state, lives, level_select, 3'b0}.

Function
REQ-017 SHALL detect jump_button rising edge via one registered sample; held button yields one start event.
REQ-018 SHALL generate tick one cycle in every CLOCK_HZ via prescaler counter; prescaler clears on every state entry.
REQ-019 PRE: level_select=0; start event -> PLAY, level_select=current level, seconds=LEVEL_SECONDS, level_reset pulsed on the transition cycle.
REQ-020 PLAY: seconds decrements on tick, saturating at 0; level_win -> WIN; level_lose or seconds==0 -> LOSE.
REQ-021 Simultaneous level_win with level_lose or timeout in PLAY SHALL resolve to WIN.
REQ-022 level_win/level_lose SHALL be ignored outside PLAY and during the level_reset cycle plus one cycle after.
REQ-023 WIN: hold HOLD_SECONDS ticks; then if current level==NUM_LEVELS -> DONE, else level+1 -> PRE.
REQ-024 LOSE: hold HOLD_SECONDS ticks; lives decrement on LOSE entry; lives==0 after decrement -> OVER, else -> PRE with same level.
REQ-025 OVER and DONE: seconds frozen; start event -> PRE, level=1, lives=START_LIVES.
REQ-026 level_reset SHALL be exactly one cycle wide, asserted only on PRE->PLAY transition.
REQ-027 seconds SHALL hold its value in all states other than PLAY; outputs registered, change one cycle after causing event.

Reset
REQ-028 reset SHALL force: game_state=PRE, current level=1, level_select=0, seconds=LEVEL_SECONDS, lives=START_LIVES, level_reset=0, prescaler=0, hold counter=0, edge register=1 (button held through reset does not start).
REQ-029 reset asserted mid-PLAY or mid-hold SHALL take effect next edge, overriding all transitions.

Configuration
REQ-030 Macro LEVEL_SEQ_LIVES_EN defined: lives counting and OVER state per REQ-024/025.
REQ-031 Macro LEVEL_SEQ_LIVES_EN undefined: no lives register, lives output constant START_LIVES, LOSE always returns to PRE same level, OVER unreachable.

Verification (CLOCK_HZ=10, LEVEL_SECONDS=5, HOLD_SECONDS=2, NUM_LEVELS=3, START_LIVES=3)
REQ-032 Reset, press jump_button 1 cycle -> next cycle game_state=1, level_select=1, level_reset high exactly 1 cycle, seconds=5.
REQ-033 PLAY no flags 50 cycles -> seconds 5..0 one step per 10 cycles, then LOSE, lives=2, after 20 cycles PRE, level_select=0.
REQ-034 PLAY, assert level_win and level_lose same cycle -> WIN, lives unchanged; after 20 cycles PRE, next start gives level_select=2.
REQ-035 Win levels 1,2,3 in sequence -> DONE; start -> PRE, level 1, lives=3.
REQ-036 Three timeouts with LEVEL_SEQ_LIVES_EN -> OVER, lives=0; without macro -> PRE each time, lives=3.
REQ-037 Hold jump_button through reset release and 30 cycles -> stays PRE; reset asserted mid-PLAY -> all REQ-028 values next cycle.
